// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter: FSM states, dm_ctrl codes, access payload.
package dm_bus_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DMCTRL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // dm_ctrl access size/sign codes, shared with the CPU load/store unit
    localparam logic [DMCTRL_W-1:0] DM_LB  = 3'b000;
    localparam logic [DMCTRL_W-1:0] DM_LH  = 3'b001;
    localparam logic [DMCTRL_W-1:0] DM_LW  = 3'b010;
    localparam logic [DMCTRL_W-1:0] DM_LBU = 3'b011;
    localparam logic [DMCTRL_W-1:0] DM_LHU = 3'b100;

    typedef struct packed {
        logic                we;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
        logic [DMCTRL_W-1:0] dmctrl;
    } dm_acc_t;

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Bundle of both master ports, the memory-slave port and status outputs of the arbiter.
interface dm_bus_arbiter_if;
    import dm_bus_arbiter_pkg::*;

    logic                m0_req;
    logic                m0_we;
    logic [XLEN-1:0]     m0_addr;
    logic [XLEN-1:0]     m0_wdata;
    logic [DMCTRL_W-1:0] m0_dmctrl;
    logic                m0_ack;

    logic                m1_req;
    logic                m1_we;
    logic [XLEN-1:0]     m1_addr;
    logic [XLEN-1:0]     m1_wdata;
    logic [DMCTRL_W-1:0] m1_dmctrl;
    logic                m1_ack;

    logic [XLEN-1:0]     m_rdata;
    logic                m_err;

    logic                s_req;
    logic                s_we;
    logic [XLEN-1:0]     s_addr;
    logic [XLEN-1:0]     s_wdata;
    logic [DMCTRL_W-1:0] s_dmctrl;
    logic [XLEN-1:0]     s_rdata;
    logic                s_ack;

    logic                cpu_stall;
    logic                busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_dmctrl,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_dmctrl,
        input  s_rdata, s_ack,
        output m0_ack, m1_ack, m_rdata, m_err,
        output s_req, s_we, s_addr, s_wdata, s_dmctrl,
        output cpu_stall, busy
    );

    // Environment side: requesting masters plus the memory slave
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_dmctrl,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_dmctrl,
        output s_rdata, s_ack,
        input  m0_ack, m1_ack, m_rdata, m_err,
        input  s_req, s_we, s_addr, s_wdata, s_dmctrl,
        input  cpu_stall, busy
    );

endinterface

// File: rtl/dm_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to i_prio.
module dm_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);

    assign o_gnt_valid = |i_req;
    assign o_gnt_idx   = (&i_req) ? i_prio : i_req[1];

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory/MMIO port between CPU (m0) and a second master (m1),
// with slave-ack timeout and registered response data.
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    dm_bus_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       r_state;
    logic             r_sel;
    logic             r_prio;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rdata;
    logic             r_err;
    logic             r_m0_ack;
    logic             r_m1_ack;
    logic             r_s_req;
    dm_acc_t          r_s_acc;
    logic             r_busy;

    logic             w_gnt_valid;
    logic             w_gnt_idx;
    dm_acc_t          w_m0_acc;
    dm_acc_t          w_m1_acc;
    dm_acc_t          w_win_acc;

    dm_rr_pick u_pick (
        .i_req       ({bus.m1_req, bus.m0_req}),
        .i_prio      (r_prio),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_m0_acc  = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata, dmctrl: bus.m0_dmctrl};
    assign w_m1_acc  = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata, dmctrl: bus.m1_dmctrl};
    assign w_win_acc = w_gnt_idx ? w_m1_acc : w_m0_acc;

    // Slave-side fields are latched at grant; masters hold them stable until ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_sel    <= 1'b0;
            r_prio   <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            r_s_req  <= 1'b0;
            r_s_acc  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_sel   <= w_gnt_idx;
                        r_prio  <= ~w_gnt_idx;
                        r_cnt   <= '0;
                        r_s_req <= 1'b1;
                        r_s_acc <= w_win_acc;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A slave ack in the final timeout cycle still wins over the error.
                    if (bus.s_ack || (r_cnt == CNT_LAST)) begin
                        r_rdata  <= bus.s_ack ? bus.s_rdata : '0;
                        r_err    <= ~bus.s_ack;
                        r_m0_ack <= ~r_sel;
                        r_m1_ack <= r_sel;
                        r_s_req  <= 1'b0;
                        r_s_acc  <= '0;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_s_req <= 1'b0;
                    r_s_acc <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ack    = r_m0_ack;
    assign bus.m1_ack    = r_m1_ack;
    assign bus.m_rdata   = r_rdata;
    assign bus.m_err     = r_err;
    assign bus.s_req     = r_s_req;
    assign bus.s_we      = r_s_acc.we;
    assign bus.s_addr    = r_s_acc.addr;
    assign bus.s_wdata   = r_s_acc.wdata;
    assign bus.s_dmctrl  = r_s_acc.dmctrl;
    assign bus.busy      = r_busy;
    assign bus.cpu_stall = bus.m0_req & ~r_m0_ack;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter (TIMEOUT=4): latency, alternation, timeout, passthrough, reset.
module tb_dm_bus_arbiter;
    import dm_bus_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    dm_bus_arbiter_if bus ();

    dm_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sreq;
        for (int n = 0; n < 10 && !bus.s_req; n++) tick();
        chk("sreq_seen", 32'(bus.s_req), 32'd1);
    endtask

    // Serve one transaction, expecting master exp_idx to be the one on the slave port.
    task automatic serve(input logic exp_idx, input logic [31:0] data);
        wait_sreq();
        chk("serve_addr", bus.s_addr, exp_idx ? bus.m1_addr : bus.m0_addr);
        bus.s_ack   = 1'b1;
        bus.s_rdata = data;
        tick();
        bus.s_ack = 1'b0;
        chk("serve_m0_ack", 32'(bus.m0_ack), 32'(!exp_idx));
        chk("serve_m1_ack", 32'(bus.m1_ack), 32'(exp_idx));
        chk("serve_rdata", bus.m_rdata, data);
        chk("serve_err", 32'(bus.m_err), 32'd0);
        tick();
    endtask

    initial begin
        int n;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_dmctrl = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_dmctrl = 0;
        bus.s_ack = 0; bus.s_rdata = 0;
        tick(); tick();

        // reset state
        chk("rst_s_req", 32'(bus.s_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_acks", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        chk("rst_rdata", bus.m_rdata, 32'd0);
        chk("rst_err", 32'(bus.m_err), 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        reset = 1'b1;
        tick();

        // single CPU read
        bus.m0_req = 1; bus.m0_addr = 32'h100; bus.m0_dmctrl = DM_LW;
        #1 chk("rd_stall_T", 32'(bus.cpu_stall), 32'd1);
        tick();
        chk("rd_sreq_T1", 32'(bus.s_req), 32'd1);
        chk("rd_saddr_T1", bus.s_addr, 32'h100);
        chk("rd_busy_T1", 32'(bus.busy), 32'd1);
        chk("rd_stall_T1", 32'(bus.cpu_stall), 32'd1);
        bus.s_ack = 1; bus.s_rdata = 32'hCAFEF00D;
        tick();
        bus.s_ack = 0;
        chk("rd_ack_T2", 32'(bus.m0_ack), 32'd1);
        chk("rd_m1ack_T2", 32'(bus.m1_ack), 32'd0);
        chk("rd_rdata_T2", bus.m_rdata, 32'hCAFEF00D);
        chk("rd_err_T2", 32'(bus.m_err), 32'd0);
        chk("rd_sreq_T2", 32'(bus.s_req), 32'd0);
        chk("rd_stall_T2", 32'(bus.cpu_stall), 32'd0);
        bus.m0_req = 0;
        tick();
        chk("rd_ack_T3", 32'(bus.m0_ack), 32'd0);
        chk("rd_busy_T3", 32'(bus.busy), 32'd0);
        chk("rd_hold_T3", bus.m_rdata, 32'hCAFEF00D);

        // contention from reset: strict alternation m0,m1,m0,m1
        reset = 0; tick(); reset = 1; tick();
        bus.m0_addr = 32'h100; bus.m1_addr = 32'h2000;
        bus.m0_req = 1; bus.m1_req = 1;
        for (int i = 0; i < 4; i++) serve(1'(i % 2), 32'h1000 + 32'(i));
        bus.m0_req = 0; bus.m1_req = 0;
        tick();

        // timeout: no slave ack
        bus.m1_req = 1;
        tick();
        n = 0;
        while (bus.s_req && n < 20) begin n++; tick(); end
        chk("to_busy_cycles", 32'(n), 32'd4);
        chk("to_m1_ack", 32'(bus.m1_ack), 32'd1);
        chk("to_m0_ack", 32'(bus.m0_ack), 32'd0);
        chk("to_err", 32'(bus.m_err), 32'd1);
        chk("to_rdata", bus.m_rdata, 32'd0);
        bus.m1_req = 0;
        tick();

        // ack in the last timeout cycle wins
        bus.m1_req = 1;
        tick(); tick(); tick(); tick();
        chk("bnd_sreq_c4", 32'(bus.s_req), 32'd1);
        bus.s_ack = 1; bus.s_rdata = 32'h12345678;
        tick();
        bus.s_ack = 0; bus.m1_req = 0;
        chk("bnd_m1_ack", 32'(bus.m1_ack), 32'd1);
        chk("bnd_err", 32'(bus.m_err), 32'd0);
        chk("bnd_rdata", bus.m_rdata, 32'h12345678);
        tick();

        // store passthrough on m1
        chk("st_idle_saddr", bus.s_addr, 32'd0);
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h2004;
        bus.m1_wdata = 32'hA5A5A5A5; bus.m1_dmctrl = 3'b010;
        tick();
        chk("st_sreq", 32'(bus.s_req), 32'd1);
        chk("st_swe", 32'(bus.s_we), 32'd1);
        chk("st_saddr", bus.s_addr, 32'h2004);
        chk("st_swdata", bus.s_wdata, 32'hA5A5A5A5);
        chk("st_sdmctrl", 32'(bus.s_dmctrl), 32'd2);
        tick();
        bus.s_ack = 1; bus.s_rdata = 32'hDEAD0001;
        tick();
        bus.s_ack = 0; bus.m1_req = 0; bus.m1_we = 0;
        chk("st_m1_ack", 32'(bus.m1_ack), 32'd1);
        chk("st_rdata", bus.m_rdata, 32'hDEAD0001);
        chk("st_resp_saddr", bus.s_addr, 32'd0);
        chk("st_resp_swdata", bus.s_wdata, 32'd0);
        chk("st_resp_swe", 32'(bus.s_we), 32'd0);
        tick();

        // spurious slave ack in IDLE is ignored
        bus.s_ack = 1;
        tick(); tick();
        bus.s_ack = 0;
        chk("sp_acks", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        chk("sp_busy", 32'(bus.busy), 32'd0);

        // reset mid-BUSY (m0 granted, so prio points at m1 before the reset)
        bus.m0_req = 1;
        tick();
        chk("rb_sreq_before", 32'(bus.s_req), 32'd1);
        reset = 0;
        #1;
        chk("rb_sreq", 32'(bus.s_req), 32'd0);
        chk("rb_busy", 32'(bus.busy), 32'd0);
        chk("rb_acks", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        chk("rb_rdata", bus.m_rdata, 32'd0);
        tick();
        chk("rb_no_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        reset = 1;
        tick();
        // prio back to m0: both requesting, m0 first, then the m1 request is served normally
        bus.m1_req = 1;
        serve(1'b0, 32'h0BAD0000);
        bus.m0_req = 0;
        serve(1'b1, 32'h0000BEEF);
        bus.m1_req = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dm_bus_arbiter.md
# dm_bus_arbiter

Two-master arbiter that shares the single data-memory/MMIO port between the CPU data interface and a second requester (DMA or debug loader). Runs a round-robin grant, forwards the winner's access to the memory slave, waits for the slave acknowledge with a timeout, and returns registered read data. It sits between the CPU's memory-side outputs and the data memory / I/O decoder, and provides a stall indication the CPU uses to hold its PC.

## Interface
- TIMEOUT, 16: maximum BUSY cycles waiting for `s_ack` before an error response; must be ≥ 2.
- CNT_W, $clog2(TIMEOUT): width of the timeout counter.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- m0_req  in  1  CPU access request; held until `m0_ack`.
- m0_we  in  1  CPU write enable (1 = store).
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU store data.
- m0_dmctrl  in  3  CPU access size/sign code (dm_ctrl encoding).
- m0_ack  out  1  one-cycle completion pulse to CPU.
- m1_req, m1_we, m1_addr, m1_wdata, m1_dmctrl  in  1/1/32/32/3  second master, same meaning as m0.
- m1_ack  out  1  one-cycle completion pulse to master 1.
- m_rdata  out  32  registered read data, valid with either ack.
- m_err  out  1  registered error flag (timeout), valid with either ack.
- s_req, s_we, s_addr, s_wdata, s_dmctrl  out  1/1/32/32/3  access presented to the memory slave.
- s_rdata  in  32  slave read data, sampled when `s_ack`=1.
- s_ack  in  1  slave completion, honoured only in BUSY.
- cpu_stall  out  1  `m0_req & ~m0_ack` (combinational).
- busy  out  1  1 whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if neither request is asserted, stay. If only one is asserted, grant it. If both are asserted, grant the master indicated by `prio`. On grant: register `sel`, set `prio` to the other master, clear the counter, go to BUSY.
- BUSY: `s_req`=1; `s_we/s_addr/s_wdata/s_dmctrl` are muxed from master `sel`.
  - If `s_ack`=1: capture `s_rdata` into `rdata_q`, set `err_q`=0, go to RESP.
  - Else, if counter = TIMEOUT-1: `rdata_q`=0, `err_q`=1, go to RESP.
  - Else: counter +1.
- RESP: `m{sel}_ack`=1 for exactly one cycle; `m_rdata`=`rdata_q`, `m_err`=`err_q`; go to IDLE. `s_req`=0.
- Outside BUSY, `s_*` outputs are 0. `m_rdata`/`m_err` hold their last value between responses.
- Writes complete the same way as reads; `m_rdata` on a write is whatever the slave returned.
- The counter saturates at TIMEOUT-1 (no wrap). Width arithmetic is unsigned, CNT_W bits.

## Timing
- Reset values: state=IDLE, sel=0, prio=0 (m0 first), counter=0, rdata_q=0, err_q=0, all acks=0, `s_*`=0, busy=0. `cpu_stall` follows `m0_req`.
- Latency: request seen in IDLE at cycle T → `s_req` at T+1 → if `s_ack` arrives at T+k (k ≥ 1), master ack at T+k+1. Next arbitration happens at T+k+2. The minimum request-to-ack time is 2 cycles.
- Timeout: with no `s_ack`, BUSY lasts exactly TIMEOUT cycles and the ack with `m_err`=1 follows.
- If `s_ack` is high in the same cycle the timeout is reached, the ack wins: `err_q`=0 and data is captured.
- Masters must hold their request fields stable from `req` to `ack`. Dropping `req` mid-transaction does not abort it; the ack is still issued.
- A master that keeps `req` high after its ack is a new request in the following IDLE cycle. If the other master is waiting, the other master wins (strict alternation under contention).
- A late `s_ack` arriving in IDLE or RESP is ignored.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously). No ack is issued and the transaction is lost.

## Structure
- Shared package/define file (alongside the existing control encodings) holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - the `dm_ctrl` width and codes, reused unchanged.
- One natural sub-module: `dm_rr_pick`, a combinational 2-way round-robin picker (inputs req[1:0] and prio; outputs `gnt_valid` and `gnt_idx`). The FSM, counter and data registers live in the top.

## Test plan
- Single CPU read: m0_req, addr 0x100, slave acks 1 cycle after `s_req` with 0xCAFEF00D → m0_ack at T+2, m_rdata=0xCAFEF00D, m_err=0, cpu_stall high T..T+1.
- Contention: both masters request from reset → m0 served first, then m1. With both held high, grants alternate m0,m1,m0,m1 and each ack goes only to its own master.
- Timeout with TIMEOUT=4, slave never acks → exactly 4 BUSY cycles, then m1_ack with m_err=1 and m_rdata=0.
- Ack at the boundary: `s_ack` in the 4th BUSY cycle (TIMEOUT=4) with data 0x12345678 → m_err=0, m_rdata=0x12345678.
- Store passthrough: m1 write, addr 0x2004, wdata 0xA5A5A5A5, dmctrl 3'b010 → `s_*` carry those exact values only while BUSY, zeros otherwise. A spurious `s_ack` in IDLE produces no ack.
- Reset mid-BUSY: drive reset low while `s_req`=1 → `s_req`, busy and acks go to 0 the same cycle. After release, prio=0 and a new m1 request is served normally.
